onehot_decoder_seq: RTL and testbench
=====================================

Name: onehot_decoder_seq

Overview:
- Sequenced binary-to-one-hot decoder: the companion to the team's 4:2 one-hot encoder.
- Accepts a binary code over a valid/ready handshake.
- Drives the matching one-hot line for a programmable number of cycles, then forces one guard cycle of all-zero before accepting the next code.
- Sits between control logic and one-hot select/strobe lines: mux selects, bank enables, LED/segment strobes.

Parameters:
- IN_W, 2, code width; output width is 2**IN_W (default 4).
- HOLD_W, 4, width of hold_cycles and of the internal hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; low = idle and abort.
- in_valid  input  1  code offered.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  IN_W  binary code to decode.
- hold_cycles  input  HOLD_W  cycles to assert the output; sampled only at accept.
- out_onehot  output  2**IN_W  registered one-hot output; all-zero when not driving.
- out_valid  output  1  high exactly while out_onehot is non-zero.
- busy  output  1  high in DRIVE or GAP.
- err  output  1  one-cycle parity error pulse; exists only with the optional feature.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n. While rst_n=0:
  - state=IDLE, hold counter=0, latched code=0.
  - out_onehot=0, out_valid=0, in_ready=0, busy=0, err=0.
- All outputs are registered, except in_ready, which is combinational from state and en.
- FSM states: IDLE, DRIVE, GAP.
- IDLE:
  - in_ready = en.
  - Accept occurs on an edge where in_valid & in_ready = 1.
  - At accept: latch in_code; load counter with hold_cycles (value 0 treated as 1); go to DRIVE.
  - Without accept: stay in IDLE, outputs 0.
- DRIVE:
  - out_onehot = 1 << latched code; out_valid=1; busy=1; in_ready=0.
  - Latency: output is visible the cycle after the accept edge.
  - Counter decrements every edge. On the edge where counter==1, go to GAP and clear the output.
  - The output is high for exactly max(hold_cycles,1) cycles.
- GAP:
  - Lasts exactly one cycle with out_onehot=0, out_valid=0, busy=1, in_ready=0.
  - Then go to IDLE. Minimum accept-to-accept spacing is hold+2 cycles.
- en low in DRIVE or GAP: abort. Next edge goes to IDLE with outputs 0 and the counter cleared; no GAP is inserted.
- en low in IDLE: in_ready=0; in_valid is ignored, and the code is neither queued nor dropped with an error.
- in_valid high while busy: not accepted. The source must hold its code; no buffering.
- hold_cycles changes during DRIVE have no effect.
- Maximum hold is 2**HOLD_W - 1 (15 by default); the counter never wraps.
- Async reset mid-DRIVE: outputs drop to 0 immediately, without waiting for clk.
- Invariant: out_onehot is always all-zero or exactly one-hot. It is never multi-hot.

Optional Feature:
- Macro ONEHOT_DECODER_PARITY_EN.
- With the macro defined:
  - Extra input in_par (1 bit) carries even parity over in_code.
  - At the accept edge, if ^{in_code,in_par} != 0, the code is consumed (handshake completes) but not driven.
  - err pulses high for one cycle and the state stays IDLE.
- Without the macro: in_par and err ports are absent, and every accepted code is driven.

Decomposition:
- Shared package onehot_pkg holds:
  - the state enum (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2);
  - the default IN_W and HOLD_W constants;
  - a function returning the one-hot value of a code, reusable by the encoder's bench as a reference model.
- Sub-module: none required. The hold counter is small enough to inline.
- If a shared down-counter is wanted, name it hold_counter, with load, decrement and a terminal flag.

Test Plan:
- Basic decode: en=1, in_code=2, hold_cycles=3, in_valid for one cycle → out_onehot=4'b0100 for exactly 3 cycles starting the cycle after accept, then 1 GAP cycle at 0, then in_ready=1.
- Zero hold: hold_cycles=0, in_code=3 → 4'b1000 for exactly 1 cycle; codes 0..3 each produce 0001/0010/0100/1000.
- Back-pressure: in_valid held high with code=1 while busy → in_ready=0 during DRIVE/GAP; the second accept happens exactly hold+2 cycles after the first, with no extra output pulse.
- Abort: en dropped in the 2nd cycle of a hold_cycles=10 drive → out_onehot=0 on the next edge, busy=0, no GAP cycle.
- Async reset: rst_n pulled low mid-DRIVE between clock edges → out_onehot=0, out_valid=0 immediately; after release, IDLE with in_ready=en.
- Parity (macro on): in_code=2'b01, in_par=0 → err pulses 1 cycle, out_onehot stays 0; in_par=1 → 4'b0010 is driven.

Source files
------------

// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot encoder/decoder family.
// Holds the decoder state encoding, default widths and a code-to-one-hot helper.
package onehot_pkg;

    localparam int DEF_IN_W   = 2;
    localparam int DEF_HOLD_W = 4;
    localparam int DEF_OUT_W  = 1 << DEF_IN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // One-hot value of a default-width code; usable as a reference by encoder benches.
    function automatic logic [DEF_OUT_W-1:0] onehot_of(input logic [DEF_IN_W-1:0] code);
        logic [DEF_OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/onehot_decoder_seq.sv
// Sequenced binary-to-one-hot decoder: drives one line for a programmed hold, then a guard cycle.
// Optional even-parity check on the code when ONEHOT_DECODER_PARITY_EN is defined (adds in_par, err).
//
// state | meaning
// IDLE  | waiting for a code; in_ready follows en
// DRIVE | one-hot line asserted, hold counter running down
// GAP   | single all-zero guard cycle before the next accept
module onehot_decoder_seq
    import onehot_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    input  logic [HOLD_W-1:0]    hold_cycles,
    output logic [(1<<IN_W)-1:0] out_onehot,
    output logic                 out_valid,
    output logic                 busy
`ifdef ONEHOT_DECODER_PARITY_EN
    ,
    input  logic                 in_par,
    output logic                 err
`endif
);

    localparam int OUT_W = 1 << IN_W;

    state_t             r_state;
    state_t             w_state_nx;
    logic [HOLD_W-1:0]  r_cnt;
    logic [HOLD_W-1:0]  w_cnt_nx;
    logic [HOLD_W-1:0]  w_hold_eff;
    logic [IN_W-1:0]    r_code;
    logic [IN_W-1:0]    w_code_nx;
    logic [OUT_W-1:0]   r_onehot;
    logic [OUT_W-1:0]   w_onehot_nx;
    logic               r_valid;
    logic               w_valid_nx;
    logic               r_busy;
    logic               w_busy_nx;
    logic               w_accept;
    logic               w_par_ok;
`ifdef ONEHOT_DECODER_PARITY_EN
    logic               r_err;
    logic               w_err_nx;
`endif

    // Gated by rst_n so the source never sees a handshake while the block is held in reset.
    assign in_ready   = rst_n & en & (r_state == IDLE);
    assign w_accept   = in_valid & in_ready;
    assign w_hold_eff = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;

`ifdef ONEHOT_DECODER_PARITY_EN
    assign w_par_ok = ~^{in_code, in_par};
`else
    assign w_par_ok = 1'b1;
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_code_nx   = r_code;
        w_onehot_nx = '0;
        w_valid_nx  = 1'b0;
        w_busy_nx   = 1'b0;
`ifdef ONEHOT_DECODER_PARITY_EN
        w_err_nx    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_code_nx = in_code;
                    if (w_par_ok) begin
                        w_state_nx  = DRIVE;
                        w_cnt_nx    = w_hold_eff;
                        w_onehot_nx = OUT_W'(1) << in_code;
                        w_valid_nx  = 1'b1;
                        w_busy_nx   = 1'b1;
                    end else begin
`ifdef ONEHOT_DECODER_PARITY_EN
                        w_err_nx = 1'b1;
`endif
                    end
                end
            end
            DRIVE: begin
                if (!en) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt <= HOLD_W'(1)) begin
                    w_state_nx = GAP;
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b1;
                end else begin
                    w_cnt_nx    = r_cnt - HOLD_W'(1);
                    w_onehot_nx = OUT_W'(1) << r_code;
                    w_valid_nx  = 1'b1;
                    w_busy_nx   = 1'b1;
                end
            end
            GAP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_code   <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_code   <= w_code_nx;
            r_onehot <= w_onehot_nx;
            r_valid  <= w_valid_nx;
            r_busy   <= w_busy_nx;
        end
    end

`ifdef ONEHOT_DECODER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nx;
        end
    end

    assign err = r_err;
`endif

    assign out_onehot = r_onehot;
    assign out_valid  = r_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Scoreboard bench for onehot_decoder_seq: cycle-level pulse model, monitor compares whole pulses.
// Parity stimulus and err checks are enabled when ONEHOT_DECODER_PARITY_EN is defined.
module tb_onehot_decoder_seq;

    localparam int IN_W   = 2;
    localparam int HOLD_W = 4;
    localparam int OUT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_code = '0;
    logic [HOLD_W-1:0] hold_cycles = '0;
    logic [OUT_W-1:0]  out_onehot;
    logic              out_valid;
    logic              busy;
`ifdef ONEHOT_DECODER_PARITY_EN
    logic              in_par = 1'b0;
    logic              err;
`endif

    onehot_decoder_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .hold_cycles (hold_cycles),
        .out_onehot  (out_onehot),
        .out_valid   (out_valid),
        .busy        (busy)
`ifdef ONEHOT_DECODER_PARITY_EN
        ,
        .in_par      (in_par),
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int start;
        int len;
    } pulse_t;

    pulse_t exp_q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     busy_until = -1000;
    bit     exp_ready = 1'b0;
    bit     exp_busy = 1'b0;
    bit     exp_err = 1'b0;
    bit     err_next = 1'b0;
    bit     mon_on = 1'b0;
    int     run_len = 0;
    int     run_start = 0;
    int     run_val = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: interval k is busy while k <= busy_until; an accept at k
    // yields a pulse on k+1 .. k+h, a guard on k+h+1, ready again from k+h+2.
    task automatic drive_cycle(input bit e, input bit v, input int code, input int hold, input bit bad);
        int     k;
        int     h;
        bit     b;
        pulse_t p;
        @(posedge clk);
        #1;
        k           = cyc;
        b           = 1'b0;
`ifdef ONEHOT_DECODER_PARITY_EN
        b           = bad;
`endif
        en          = e;
        in_valid    = v;
        in_code     = code[IN_W-1:0];
        hold_cycles = hold[HOLD_W-1:0];
`ifdef ONEHOT_DECODER_PARITY_EN
        in_par      = (^in_code) ^ b;
`endif
        exp_busy  = (k <= busy_until);
        exp_ready = e && !exp_busy;
        exp_err   = err_next;
        err_next  = 1'b0;
        if (v && exp_ready) begin
            if (b) begin
                err_next = 1'b1;
            end else begin
                h       = (hold == 0) ? 1 : hold;
                p.val   = 1 << code;
                p.start = k + 1;
                p.len   = h;
                exp_q.push_back(p);
                busy_until = k + 1 + h;
            end
        end else if (!e && exp_busy) begin
            if (exp_q.size() > 0) begin
                p = exp_q.pop_back();
                if (p.start <= k && k < p.start + p.len) p.len = k - p.start + 1;
                exp_q.push_back(p);
            end
            busy_until = k;
        end
        mon_on = 1'b1;
    endtask

    always @(negedge clk) begin
        pulse_t p;
        if (!rst_n || !mon_on) begin
            run_len = 0;
        end else begin
            check("in_ready", int'(in_ready), int'(exp_ready));
            check("busy", int'(busy), int'(exp_busy));
            check("valid_vs_data", int'(out_valid), int'(out_onehot != '0));
            check("onehot0", int'($onehot0(out_onehot)), 1);
`ifdef ONEHOT_DECODER_PARITY_EN
            check("err", int'(err), int'(exp_err));
`endif
            if (out_valid) begin
                if (run_len == 0) begin
                    run_start = cyc;
                    run_val   = int'(out_onehot);
                end else begin
                    check("pulse_stable", int'(out_onehot), run_val);
                end
                run_len++;
            end else if (run_len > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", run_val, 0);
                end else begin
                    p = exp_q.pop_front();
                    check("pulse_value", run_val, p.val);
                    check("pulse_start", run_start, p.start);
                    check("pulse_len", run_len, p.len);
                end
                run_len = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: requests are offered but must not be seen.
        en          = 1'b1;
        in_valid    = 1'b1;
        in_code     = 2'd2;
        hold_cycles = 4'd3;
        #3;
        check("rst_onehot", int'(out_onehot), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_held", int'(in_ready), 0);
        check("rst_onehot_held", int'(out_onehot), 0);
        en       = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic decode.
        drive_cycle(1, 1, 2, 3, 0);
        repeat (6) drive_cycle(1, 0, 0, 0, 0);

        // Zero hold on every code.
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1, 1, c, 0, 0);
            repeat (2) drive_cycle(1, 0, 0, 0, 0);
        end

        // Back-pressure: request held through DRIVE and GAP.
        repeat (14) drive_cycle(1, 1, 1, 4, 0);
        repeat (3) drive_cycle(1, 0, 0, 0, 0);

        // hold_cycles changing mid-drive is ignored; maximum hold.
        drive_cycle(1, 1, 0, 5, 0);
        repeat (8) drive_cycle(1, 0, 0, 15, 0);
        drive_cycle(1, 1, 3, 15, 0);
        repeat (18) drive_cycle(1, 0, 0, 0, 0);

        // Abort in the second drive cycle.
        drive_cycle(1, 1, 3, 10, 0);
        drive_cycle(1, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);
        repeat (3) drive_cycle(1, 0, 0, 0, 0);

        // en low in IDLE ignores requests.
        repeat (3) drive_cycle(0, 1, 2, 2, 0);
        repeat (5) drive_cycle(1, 0, 0, 0, 0);

        // Async reset mid-drive.
        drive_cycle(1, 1, 2, 8, 0);
        repeat (2) drive_cycle(1, 0, 0, 0, 0);
        #2;
        check("pre_reset_valid", int'(out_valid), 1);
        mon_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_onehot", int'(out_onehot), 0);
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_busy", int'(busy), 0);
        exp_q.delete();
        err_next = 1'b0;
        @(negedge clk);
        #1;
        en       = 1'b1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("post_reset_ready", int'(in_ready), 1);
        busy_until = -1000;
        repeat (3) drive_cycle(1, 0, 0, 0, 0);

`ifdef ONEHOT_DECODER_PARITY_EN
        // Bad parity is consumed without output; good parity drives.
        drive_cycle(1, 1, 1, 2, 1);
        repeat (2) drive_cycle(1, 0, 0, 0, 0);
        drive_cycle(1, 1, 1, 2, 0);
        repeat (4) drive_cycle(1, 0, 0, 0, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit e;
            bit v;
            bit bad;
            int code;
            int hold;
            e    = ($urandom_range(0, 19) != 0);
            v    = ($urandom_range(0, 2) != 0);
            code = $urandom_range(0, 3);
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
            bad  = ($urandom_range(0, 7) == 0);
            drive_cycle(e, v, code, hold, bad);
        end

        repeat (20) drive_cycle(1, 0, 0, 0, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
